// File: rtl/galvo_pos_pid.sv
// Galvo position-loop PID: samples the encoder count against a command on a fixed tick.
// One shared multiplier is stepped through P, I and D terms by a small FSM.
module galvo_pos_pid #(
    parameter int PERIOD  = 50000,
    parameter int FRAC    = 8,
    parameter int OUT_W   = 16,
    parameter int INT_LIM = 1048575
) (
    input  logic                    sys_clk,
    input  logic                    pid_rst,
    input  logic                    pid_en,
    input  logic signed [31:0]      pos_ref,
    input  logic signed [31:0]      enc_pos,
    input  logic signed [31:0]      enc_vel,
    input  logic        [15:0]      kp,
    input  logic        [15:0]      ki,
    input  logic        [15:0]      kd,
    output logic signed [OUT_W-1:0] dac_out,
    output logic                    out_valid,
    output logic                    sat
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PERIOD - 1);
    localparam logic signed [24:0] LIM_P = 25'(INT_LIM);
    localparam logic signed [24:0] LIM_N = -LIM_P;
    localparam logic signed [43:0] O_MAX = 44'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [43:0] O_MIN = -O_MAX - 44'sd1;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_INTEG, S_MUL_P, S_MUL_I, S_MUL_D, S_SUM, S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]   r_div_cnt;
    logic               w_tick;
    logic        [15:0] r_kp;
    logic        [15:0] r_ki;
    logic        [15:0] r_kd;
    logic signed [23:0] r_err;
    logic signed [23:0] r_vel;
    logic signed [23:0] r_int;
    logic signed [43:0] r_acc;

    logic signed [32:0] w_err33;
    logic signed [24:0] w_int_sum;
    logic signed [23:0] w_int_nxt;
    logic signed [16:0] w_mul_a;
    logic signed [23:0] w_mul_b;
    logic signed [40:0] w_prod;
    logic signed [43:0] w_prod44;
    logic signed [43:0] w_y;
    logic signed [OUT_W-1:0] w_clip;
    logic               w_hit;

    function automatic logic signed [23:0] f_sat24(input logic signed [32:0] v);
        if (v > 33'sd8388607)
            return 24'sd8388607;
        else if (v < -33'sd8388607)
            return -24'sd8388607;
        else
            return v[23:0];
    endfunction

    assign w_tick  = (r_div_cnt == CNT_TOP) && pid_en;
    assign w_err33 = {pos_ref[31], pos_ref} - {enc_pos[31], enc_pos};

    assign w_int_sum = {r_int[23], r_int} + {r_err[23], r_err};
    assign w_int_nxt = (w_int_sum > LIM_P) ? LIM_P[23:0] :
                       (w_int_sum < LIM_N) ? LIM_N[23:0] :
                       w_int_sum[23:0];

    always_comb begin
        w_mul_a = {1'b0, r_kp};
        w_mul_b = r_err;
        case (r_state)
            S_MUL_I: begin
                w_mul_a = {1'b0, r_ki};
                w_mul_b = r_int;
            end
            S_MUL_D: begin
                w_mul_a = {1'b0, r_kd};
                w_mul_b = r_vel;
            end
            default: ;
        endcase
    end

    assign w_prod   = $signed(41'(w_mul_a)) * $signed(41'(w_mul_b));
    assign w_prod44 = {{3{w_prod[40]}}, w_prod};

    // Arithmetic shift floors toward -inf, so -1.5 becomes -2.
    assign w_y    = r_acc >>> FRAC;
    assign w_hit  = (w_y > O_MAX) || (w_y < O_MIN);
    assign w_clip = (w_y > O_MAX) ? O_MAX[OUT_W-1:0] :
                    (w_y < O_MIN) ? O_MIN[OUT_W-1:0] :
                    w_y[OUT_W-1:0];

    always_ff @(posedge sys_clk or posedge pid_rst) begin
        if (pid_rst)
            r_div_cnt <= '0;
        else if (r_div_cnt == CNT_TOP)
            r_div_cnt <= '0;
        else
            r_div_cnt <= r_div_cnt + CNT_W'(1);
    end

    always_ff @(posedge sys_clk or posedge pid_rst) begin
        if (pid_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_next = S_LATCH;
            S_LATCH: w_next = S_INTEG;
            S_INTEG: w_next = S_MUL_P;
            S_MUL_P: w_next = S_MUL_I;
            S_MUL_I: w_next = S_MUL_D;
            S_MUL_D: w_next = S_SUM;
            S_SUM:   w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (!pid_en)
            w_next = S_IDLE;
    end

    always_ff @(posedge sys_clk or posedge pid_rst) begin
        if (pid_rst) begin
            r_kp      <= '0;
            r_ki      <= '0;
            r_kd      <= '0;
            r_err     <= '0;
            r_vel     <= '0;
            r_int     <= '0;
            r_acc     <= '0;
            dac_out   <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (!pid_en) begin
            r_int     <= '0;
            dac_out   <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_LATCH: begin
                    r_kp  <= kp;
                    r_ki  <= ki;
                    r_kd  <= kd;
                    r_err <= f_sat24(w_err33);
                    r_vel <= f_sat24({enc_vel[31], enc_vel});
                end
                S_INTEG: r_int <= w_int_nxt;
                S_MUL_P: r_acc <= w_prod44;
                S_MUL_I: r_acc <= r_acc + w_prod44;
                S_MUL_D: r_acc <= r_acc - w_prod44;
                // Registering here makes the pulse and new code coincide in OUT.
                S_SUM: begin
                    dac_out   <= w_clip;
                    sat       <= w_hit;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_galvo_pos_pid.sv
// Bench for galvo_pos_pid: arithmetic reference model checked every cycle,
// plus directed scenarios pinned by hand-computed literals.
module tb_galvo_pos_pid;

    localparam int PERIOD  = 20;
    localparam int FRAC    = 8;
    localparam int OUT_W   = 16;
    localparam int INT_LIM = 1048575;

    logic sys_clk = 1'b0;
    logic pid_rst;
    logic pid_en;
    logic signed [31:0] pos_ref;
    logic signed [31:0] enc_pos;
    logic signed [31:0] enc_vel;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic signed [OUT_W-1:0] dac_out;
    logic out_valid;
    logic sat;

    int n_checks = 0;
    int n_errors = 0;

    int     n_cyc     = 0;
    bit     m_busy    = 1'b0;
    int     m_t0      = 0;
    longint m_int     = 0;
    longint m_y       = 0;
    longint exp_dac   = 0;
    bit     exp_sat   = 1'b0;
    bit     exp_valid = 1'b0;

    galvo_pos_pid #(
        .PERIOD(PERIOD), .FRAC(FRAC), .OUT_W(OUT_W), .INT_LIM(INT_LIM)
    ) dut (
        .sys_clk(sys_clk), .pid_rst(pid_rst), .pid_en(pid_en),
        .pos_ref(pos_ref), .enc_pos(enc_pos), .enc_vel(enc_vel),
        .kp(kp), .ki(ki), .kd(kd),
        .dac_out(dac_out), .out_valid(out_valid), .sat(sat)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat24(input longint v);
        if (v > 8388607) return 8388607;
        if (v < -8388607) return -8388607;
        return v;
    endfunction

    function automatic longint integ(input longint i, input longint e);
        longint s = i + e;
        if (s > INT_LIM) return INT_LIM;
        if (s < -INT_LIM) return -INT_LIM;
        return s;
    endfunction

    function automatic longint pid_y(input longint e, input longint v,
                                     input longint p, input longint ii,
                                     input longint d, input longint it);
        return (p * e + ii * it - d * v) >>> FRAC;
    endfunction

    function automatic longint clip_out(input longint y);
        longint hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        if (y > hi) return hi;
        if (y < -hi - 1) return -hi - 1;
        return y;
    endfunction

    // Reference: tick at cycle T, inputs taken at end of T+1, result shown in T+7.
    always @(posedge sys_clk or posedge pid_rst) begin
        if (pid_rst) begin
            n_cyc     <= 0;
            m_busy    <= 1'b0;
            m_t0      <= 0;
            m_int     <= 0;
            m_y       <= 0;
            exp_dac   <= 0;
            exp_sat   <= 1'b0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= 1'b0;
            n_cyc     <= n_cyc + 1;
            if (!pid_en) begin
                m_busy  <= 1'b0;
                m_int   <= 0;
                exp_dac <= 0;
                exp_sat <= 1'b0;
            end else if (m_busy) begin
                if (n_cyc == m_t0 + 1) begin
                    m_int <= integ(m_int,
                        sat24(longint'(pos_ref) - longint'(enc_pos)));
                    m_y <= pid_y(
                        sat24(longint'(pos_ref) - longint'(enc_pos)),
                        sat24(longint'(enc_vel)),
                        longint'(kp), longint'(ki), longint'(kd),
                        integ(m_int,
                            sat24(longint'(pos_ref) - longint'(enc_pos))));
                end
                if (n_cyc == m_t0 + 6) begin
                    exp_dac   <= clip_out(m_y);
                    exp_sat   <= (clip_out(m_y) != m_y);
                    exp_valid <= 1'b1;
                end
                if (n_cyc == m_t0 + 7)
                    m_busy <= 1'b0;
            end else if (n_cyc % PERIOD == PERIOD - 1) begin
                m_busy <= 1'b1;
                m_t0   <= n_cyc;
            end
        end
    end

    always @(negedge sys_clk) begin
        chk("valid", out_valid, exp_valid);
        chk("dac", dac_out, exp_dac);
        chk("sat", sat, exp_sat);
    end

    task automatic wait_valid(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 45 && !got; i++) begin
            @(negedge sys_clk);
            if (out_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: out_valid got none expected pulse within 45 cycles", name);
        end
    endtask

    task automatic clr_int();
        pid_en = 1'b0;
        repeat (2) @(negedge sys_clk);
        pid_en = 1'b1;
    endtask

    initial begin
        int cnt;
        pid_rst = 1'b0;
        pid_en  = 1'b0;
        pos_ref = 0;
        enc_pos = 0;
        enc_vel = 0;
        kp = 0;
        ki = 0;
        kd = 0;
        #1 pid_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_dac", dac_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sat", sat, 0);

        kp = 16'd256;
        pos_ref = 1000;
        pid_en = 1'b1;
        pid_rst = 1'b0;
        wait_valid("p1");
        chk("p_latency", n_cyc, 26);
        chk("p_1000", dac_out, 1000);
        chk("p_sat0", sat, 0);
        enc_pos = 1500;
        wait_valid("p2");
        chk("p_m500", dac_out, -500);

        pos_ref = 200000;
        enc_pos = -300000;
        wait_valid("s1");
        chk("s_pos", dac_out, 32767);
        chk("s_pos_sat", sat, 1);
        pos_ref = -200000;
        enc_pos = 300000;
        wait_valid("s2");
        chk("s_neg", dac_out, -32768);
        chk("s_neg_sat", sat, 1);
        pos_ref = 32'sh7fffffff;
        enc_pos = 32'sh80000000;
        wait_valid("s3");
        chk("s_nowrap", dac_out, 32767);

        kp = 0;
        ki = 16'd256;
        pos_ref = 10;
        enc_pos = 0;
        clr_int();
        for (int k = 1; k <= 3; k++) begin
            wait_valid("i");
            chk("i_ramp", dac_out, 10 * k);
        end
        pos_ref = 8388607;
        for (int k = 0; k < 2; k++) begin
            wait_valid("iclamp");
            chk("i_clamp", dac_out, 32767);
            chk("i_clamp_sat", sat, 1);
        end

        ki = 0;
        kd = 16'd512;
        enc_vel = -5;
        pos_ref = 0;
        wait_valid("d");
        chk("d_10", dac_out, 10);
        kd = 0;
        enc_vel = 0;
        kp = 16'd128;
        pos_ref = -3;
        wait_valid("floor");
        chk("floor_m2", dac_out, -2);

        kp = 0;
        ki = 16'd256;
        pos_ref = 10;
        clr_int();
        for (int k = 1; k <= 3; k++) begin
            wait_valid("a");
            chk("a_ramp", dac_out, 10 * k);
        end
        repeat (17) @(negedge sys_clk);
        pid_en = 1'b0;
        @(negedge sys_clk);
        chk("abort_dac0", dac_out, 0);
        cnt = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (out_valid) cnt++;
        end
        chk("abort_nopulse", cnt, 0);
        pid_en = 1'b1;
        wait_valid("a2");
        chk("abort_fresh", dac_out, 10);

        ki = 0;
        kp = 16'd256;
        pos_ref = 1000;
        wait_valid("r1");
        chk("r_pre", dac_out, 1000);
        repeat (18) @(negedge sys_clk);
        #1 pid_rst = 1'b1;
        #1;
        chk("r_async_dac", dac_out, 0);
        chk("r_async_valid", out_valid, 0);
        chk("r_async_sat", sat, 0);
        @(negedge sys_clk);
        pid_rst = 1'b0;
        wait_valid("r2");
        chk("r_latency", n_cyc, 26);
        chk("r_post", dac_out, 1000);

        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
